// File: rtl/seq_det_pkg.sv
// Shared defaults for the parametrised serial pattern detector.
package seq_det_pkg;
  localparam int                    DEF_PAT_LEN = 3;
  localparam logic [DEF_PAT_LEN-1:0] DEF_PATTERN = 3'b010;
  localparam int                    DEF_CNT_W   = 8;
endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating match counter; a clear coinciding with an increment restarts at one.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [CNT_W-1:0] count_o
);
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // next count: clear beats hold, increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = inc_i ? CNT_W'(1) : {CNT_W{1'b0}};
    end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
endmodule

// File: rtl/seq_detector_param.sv
// Serial pattern detector with loadable pattern, overlap control and a
// registered match pulse feeding a saturating occurrence counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = DEF_CNT_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  input  logic               in,
  input  logic               overlap_en,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_value,
  input  logic               count_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count
);
  localparam int FILL_W = $clog2(PAT_LEN + 1);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] hist_q, hist_d, hist_n;
  logic [FILL_W-1:0]  fill_q, fill_d, fill_n;
  logic               match_q, match_d;
  logic               hit_s;

  // next-state: pattern load wins, otherwise shift in a qualified sample
  always_comb begin
    pat_d   = pat_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    hit_s   = 1'b0;
    hist_n  = {hist_q[PAT_LEN-2:0], in};
    fill_n  = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
    if (pat_load) begin
      pat_d  = pat_value;
      fill_d = {FILL_W{1'b0}};
    end else if (in_valid) begin
      hist_d = hist_n;
      // the fill gate keeps the zeroed history from matching an all-zero prefix
      hit_s  = (fill_n == FILL_W'(PAT_LEN)) && (hist_n == pat_q);
      fill_d = (hit_s && !overlap_en) ? {FILL_W{1'b0}} : fill_n;
    end else begin
      hist_d = hist_q;
      fill_d = fill_q;
    end
    match_d = hit_s;
  end

  // detector state registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      pat_q   <= PATTERN;
      hist_q  <= {PAT_LEN{1'b0}};
      fill_q  <= {FILL_W{1'b0}};
      match_q <= 1'b0;
    end else begin
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk_i  (CLK),
    .rst_i  (RST),
    .inc_i  (hit_s),
    .clr_i  (count_clr && !pat_load),
    .count_o(match_count)
  );

  assign match = match_q;
endmodule

// File: tb/tb_seq_detector_param.sv
// Randomised and directed bench for seq_detector_param against a queue-based model.
module tb_seq_detector_param;
  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       din = 1'b0;
  logic       overlap_en = 1'b0;
  logic       pat_load = 1'b0;
  logic [2:0] pat_value = 3'b000;
  logic       count_clr = 1'b0;
  logic       match8, match2;
  logic [7:0] count8;
  logic [1:0] count2;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // model state: samples since the last history reset, oldest first
  logic       mq[$];
  logic [2:0] mpat = 3'b010;
  logic       mmatch = 1'b0;
  int         mcnt8 = 0;
  int         mcnt2 = 0;

  always #5 CLK = ~CLK;

  seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b010), .CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in(din), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_value(pat_value), .count_clr(count_clr),
    .match(match8), .match_count(count8));

  seq_detector_param #(.PAT_LEN(3), .PATTERN(3'b010), .CNT_W(2)) dut2 (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in(din), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_value(pat_value), .count_clr(count_clr),
    .match(match2), .match_count(count2));

  // reference model evaluated from the inputs seen at each rising edge
  always @(posedge CLK) begin
    logic h;
    int   v;
    h = 1'b0;
    if (RST) begin
      mpat = 3'b010; mq.delete(); mmatch = 1'b0; mcnt8 = 0; mcnt2 = 0;
    end else if (pat_load) begin
      mpat = pat_value; mq.delete(); mmatch = 1'b0;
    end else begin
      if (in_valid) begin
        mq.push_back(din);
        if (mq.size() > 3) void'(mq.pop_front());
        if (mq.size() == 3) begin
          v = 0;
          for (int i = 0; i < 3; i++) v = v * 2 + int'(mq[i]);
          h = (v == int'(mpat));
        end
        if (h && !overlap_en) mq.delete();
      end
      mmatch = h;
      if (count_clr) begin
        mcnt8 = h ? 1 : 0; mcnt2 = h ? 1 : 0;
      end else if (h) begin
        mcnt8 = (mcnt8 < 255) ? mcnt8 + 1 : 255;
        mcnt2 = (mcnt2 < 3) ? mcnt2 + 1 : 3;
      end
    end
  end

  // per-cycle comparison of both instances against the model
  always @(negedge CLK) begin
    if (chk_en) begin
      checks += 4;
      if (match8 !== mmatch) begin errors++; $display("FAIL match8 got %0b want %0b at %0t", match8, mmatch, $time); end
      if (match2 !== mmatch) begin errors++; $display("FAIL match2 got %0b want %0b at %0t", match2, mmatch, $time); end
      if (count8 !== 8'(mcnt8)) begin errors++; $display("FAIL count8 got %0d want %0d at %0t", count8, mcnt8, $time); end
      if (count2 !== 2'(mcnt2)) begin errors++; $display("FAIL count2 got %0d want %0d at %0t", count2, mcnt2, $time); end
    end
  end

  task automatic tick(input logic v, input logic b, input logic ov, input logic ld,
                      input logic [2:0] pv, input logic clr, input logic r);
    in_valid = v; din = b; overlap_en = ov; pat_load = ld;
    pat_value = pv; count_clr = clr; RST = r;
    @(posedge CLK); #1;
  endtask

  task automatic smp(input logic b, input logic ov);
    tick(1'b1, b, ov, 1'b0, 3'b000, 1'b0, 1'b0);
  endtask

  task automatic rst_cycle();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1);
  endtask

  task automatic lit(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d at %0t", name, got, want, $time);
    end
  endtask

  initial begin
    @(posedge CLK); #1;
    rst_cycle();
    chk_en = 1'b1;
    lit("reset_match", int'(match8), 0);
    lit("reset_count", int'(count8), 0);

    // 1: fill gate
    smp(1'b1, 1'b1); smp(1'b0, 1'b1);
    lit("gate_match", int'(match8), 0);
    lit("gate_count", int'(count8), 0);

    // 2: overlapping
    rst_cycle();
    smp(1'b0, 1'b1); smp(1'b1, 1'b1); smp(1'b0, 1'b1);
    lit("ov_hit3", int'(match8), 1);
    smp(1'b1, 1'b1);
    lit("ov_gap4", int'(match8), 0);
    smp(1'b0, 1'b1);
    lit("ov_hit5", int'(match8), 1);
    lit("ov_count", int'(count8), 2);

    // 3: non-overlapping
    rst_cycle();
    smp(1'b0, 1'b0); smp(1'b1, 1'b0); smp(1'b0, 1'b0);
    lit("nov_hit3", int'(match8), 1);
    smp(1'b1, 1'b0); smp(1'b0, 1'b0);
    lit("nov_no5", int'(match8), 0);
    lit("nov_count1", int'(count8), 1);
    smp(1'b0, 1'b0); smp(1'b1, 1'b0); smp(1'b0, 1'b0);
    lit("nov_hit8", int'(match8), 1);
    lit("nov_count2", int'(count8), 2);

    // 4: idle cycles hold history
    rst_cycle();
    smp(1'b0, 1'b1); smp(1'b1, 1'b1);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    lit("idle1", int'(match8), 0);
    tick(1'b0, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 1'b0);
    smp(1'b0, 1'b1);
    lit("idle_hit", int'(match8), 1);

    // 5: pattern load mid-stream
    rst_cycle();
    smp(1'b0, 1'b1); smp(1'b1, 1'b1); smp(1'b0, 1'b1);
    smp(1'b1, 1'b1); smp(1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
    lit("load_match", int'(match8), 0);
    lit("load_count", int'(count8), 1);
    smp(1'b1, 1'b1); smp(1'b1, 1'b1); smp(1'b0, 1'b1);
    lit("load_hit", int'(match8), 1);
    lit("load_count2", int'(count8), 2);

    // 6: saturation, clear with hit, reset mid-stream
    rst_cycle();
    smp(1'b0, 1'b1);
    for (int k = 0; k < 7; k++) begin
      smp(1'b1, 1'b1); smp(1'b0, 1'b1);
      lit("sat_count2", int'(count2), (k < 3) ? k + 1 : 3);
    end
    smp(1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 1'b1, 1'b0);
    lit("clr_hit2", int'(count2), 1);
    lit("clr_hit8", int'(count8), 1);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 3'b111, 1'b0, 1'b0);
    smp(1'b0, 1'b1); smp(1'b1, 1'b1);
    rst_cycle();
    lit("rst_count", int'(count8), 0);
    smp(1'b0, 1'b1); smp(1'b1, 1'b1);
    lit("rst_fresh", int'(match8), 0);
    smp(1'b0, 1'b1);
    lit("rst_pat", int'(match8), 1);

    // random phase
    for (int n = 0; n < 4000; n++) begin
      tick(($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0, 3'($urandom_range(0, 7)),
           ($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0);
    end
    @(negedge CLK);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
